// File: rtl/comparator_defs_pkg.sv
// rtl/comparator_defs_pkg.sv - shared FSM encodings and result-vector indices
package comparator_defs;

   // Two-state controller: gather bit pairs, then hold the verdict
   typedef enum logic {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } state_t;

   // Positions of the three verdict flags inside the result vector
   localparam int GT    = 0;
   localparam int LT    = 1;
   localparam int EQ    = 2;
   localparam int RES_W = 3;

endpackage

// File: rtl/comparator_bit_slice.sv
// rtl/comparator_bit_slice.sv - one step of the MSB-first "first difference decides" compare
module comparator_bit_slice (
   input  logic gt_in,
   input  logic lt_in,
   input  logic a_bit,
   input  logic b_bit,
   output logic gt_out,
   output logic lt_out
);

   logic undecided;

   // Only the first differing bit pair may set a flag; after that the verdict is frozen
   assign undecided = ~gt_in & ~lt_in;
   assign gt_out    = gt_in | (undecided &  a_bit & ~b_bit);
   assign lt_out    = lt_in | (undecided & ~a_bit &  b_bit);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial three-way magnitude comparator with valid/ready
module serial_magnitude_comparator
   import comparator_defs::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             A_greater_than_B,
   output logic             A_less_than_B,
   output logic             A_equal_B,
   output logic [CNT_W-1:0] bit_count
);

   state_t             state;
   state_t             next_state;
   logic               gt_q;
   logic               lt_q;
   logic               gt_next;
   logic               lt_next;
   logic [CNT_W-1:0]   count_q;
   logic [RES_W-1:0]   result_q;
   logic [RES_W-1:0]   result_d;
   logic               accept;
   logic               last_bit;
   logic               release_result;

   comparator_bit_slice u_slice (
      .gt_in  (gt_q),
      .lt_in  (lt_q),
      .a_bit  (a_bit),
      .b_bit  (b_bit),
      .gt_out (gt_next),
      .lt_out (lt_next)
   );

   // Verdict as it will stand once the current bit pair is folded in
   always_comb begin
      result_d     = '0;
      result_d[GT] = gt_next;
      result_d[LT] = lt_next;
      result_d[EQ] = ~gt_next & ~lt_next;
   end

   // Next-state and handshake decode; clear always returns to collection
   always_comb begin
      next_state     = state;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      accept         = 1'b0;
      last_bit       = 1'b0;
      release_result = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            accept   = in_valid;
            last_bit = in_valid && (count_q == CNT_W'(WIDTH - 1));
            if (last_bit) begin
               next_state = RESULT;
            end
         end
         RESULT: begin
            out_valid      = 1'b1;
            release_result = out_ready;
            if (out_ready) begin
               next_state = COLLECT;
            end
         end
         default: next_state = COLLECT;
      endcase
      if (clear) begin
         next_state = COLLECT;
      end
   end

   // State register; reset outranks everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= next_state;
      end
   end

   // Counter, sticky flags and verdict; clear discards any partial operand
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q  <= '0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         count_q <= count_q + CNT_W'(1);
         gt_q    <= gt_next;
         lt_q    <= lt_next;
         if (last_bit) begin
            result_q <= result_d;
         end
      end else if (release_result) begin
         count_q  <= '0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         result_q <= '0;
      end
   end

   assign A_greater_than_B = result_q[GT];
   assign A_less_than_B    = result_q[LT];
   assign A_equal_B        = result_q[EQ];
   assign bit_count        = count_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for the serial magnitude comparator
module tb_serial_magnitude_comparator;
   import comparator_defs::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             a_bit = 1'b0;
   logic             b_bit = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             A_greater_than_B;
   logic             A_less_than_B;
   logic             A_equal_B;
   logic [CNT_W-1:0] bit_count;

   typedef struct {
      int res;
      int edge_n;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   bit   mon_en = 1'b0;
   bit   seen = 1'b0;
   bit   post_hs = 1'b0;
   bit   ready_always = 1'b1;
   int   hold_target = 0;
   int   hold_cnt = 0;

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .a_bit            (a_bit),
      .b_bit            (b_bit),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .A_greater_than_B (A_greater_than_B),
      .A_less_than_B    (A_less_than_B),
      .A_equal_B        (A_equal_B),
      .bit_count        (bit_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (a > b) return GT;
      if (a < b) return LT;
      return EQ;
   endfunction

   // gap: 0 = continuous, -1 = one idle cycle before every bit, >0 = idle percentage
   task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int gap, input int abort_after);
      exp_t e;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (gap == -1) begin
            in_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
            @(posedge clk); #1;
         end else if (gap > 0) begin
            while ($urandom_range(0, 99) < gap) begin
               in_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
         for (int t = 0; !in_ready; t++) begin
            if (t > 50) begin
               check(1'b0, "in_ready_timeout", 0, 1);
               in_valid = 1'b0;
               return;
            end
            @(posedge clk); #1;
         end
         if (i == 0 && abort_after == 0) begin
            e.res = model(a, b);
            e.edge_n = cyc + 1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         if (abort_after > 0 && (WIDTH - i) == abort_after) begin
            clear = 1'b1; in_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
            @(posedge clk); #1;
            clear = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            check(bit_count == 0, "clear_bit_count", bit_count, 0);
            check(out_valid == 1'b0, "clear_out_valid", out_valid, 0);
            @(posedge clk); #1;
            return;
         end
      end
      in_valid = 1'b0;
   endtask

   // Consumer: optionally stall a fresh result, otherwise always or randomly ready
   initial begin
      forever begin
         @(posedge clk); #1;
         if (out_valid && hold_cnt < hold_target) begin
            out_ready = 1'b0;
            hold_cnt++;
         end else begin
            out_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: compare every presented result against the scoreboard head
   always @(negedge clk) begin
      if (mon_en) begin
         if (post_hs) begin
            check(out_valid == 1'b0, "handoff_out_valid", out_valid, 0);
            check(bit_count == 0, "handoff_bit_count", bit_count, 0);
            post_hs = 1'b0;
         end
         if (out_valid) begin
            check(sb.size() != 0, "unexpected_out_valid", 1, 0);
            if (sb.size() != 0) begin
               if (!seen) begin
                  check(cyc == sb[0].edge_n, "result_latency", cyc, sb[0].edge_n);
                  seen = 1'b1;
               end
               check({A_equal_B, A_less_than_B, A_greater_than_B} == 3'(1 << sb[0].res),
                     "result_value", {A_equal_B, A_less_than_B, A_greater_than_B},
                     3'(1 << sb[0].res));
               check(bit_count == WIDTH, "result_bit_count", bit_count, WIDTH);
               check(in_ready == 1'b0, "result_in_ready", in_ready, 0);
               if (out_ready || reset || clear) begin
                  void'(sb.pop_front());
                  seen = 1'b0;
                  post_hs = 1'b1;
               end
            end
         end else begin
            check({A_equal_B, A_less_than_B, A_greater_than_B} == 3'b000, "idle_result",
                  {A_equal_B, A_less_than_B, A_greater_than_B}, 0);
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
      check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
      check(bit_count == 0, "reset_bit_count", bit_count, 0);
      check({A_equal_B, A_less_than_B, A_greater_than_B} == 3'b000, "reset_result",
            {A_equal_B, A_less_than_B, A_greater_than_B}, 0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      ready_always = 1'b1;
      send_op(8'hA5, 8'h5A, 0, 0);
      send_op(8'h3C, 8'h3D, -1, 0);
      hold_cnt = 0; hold_target = 5;
      send_op(8'hFF, 8'hFF, 0, 0);
      send_op(8'h80, 8'h7F, 0, 0);
      send_op(8'h00, 8'h01, 0, 0);
      send_op(8'hF0, 8'h0F, 0, 4);
      send_op(8'h12, 8'h12, 0, 0);

      // Reset on the same edge as a consumer handshake
      send_op(8'h55, 8'hAA, 0, 0);
      for (int t = 0; !out_valid; t++) begin
         if (t > 20) begin
            check(1'b0, "reset_test_timeout", 0, 1);
            break;
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check(out_valid == 1'b0, "rst_result_out_valid", out_valid, 0);
      check(in_ready == 1'b1, "rst_result_in_ready", in_ready, 1);
      check(bit_count == 0, "rst_result_bit_count", bit_count, 0);
      @(posedge clk); #1;

      ready_always = 1'b0;
      for (int n = 0; n < 40; n++) begin
         ra = WIDTH'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
         send_op(ra, rb, 30, 0);
      end

      for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
      check(sb.size() == 0, "drain", sb.size(), 0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
